// File: rtl/palette_control_pkg.sv
// Shared command codes, widths and mode encodings for the gate-array palette block.
package palette_control_pkg;

    typedef enum logic [1:0] {
        CMD_PEN = 2'b00,
        CMD_INK = 2'b01,
        CMD_CFG = 2'b10,
        CMD_RAM = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        MODE_0 = 2'd0,
        MODE_1 = 2'd1,
        MODE_2 = 2'd2,
        MODE_3 = 2'd3
    } mode_e;

    localparam int unsigned COLOUR_W  = 5;
    localparam int unsigned INK_COUNT = 16;
    localparam int unsigned PEN_W     = 5;

endpackage

// File: rtl/ink_palette.sv
// 16-entry ink store plus border colour, presented as per-bit planes across all inks.
module ink_palette
    import palette_control_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        wr_border,
    input  logic [3:0]  wr_idx,
    input  logic [4:0]  wr_data,
    output logic [15:0] inkr0,
    output logic [15:0] inkr1,
    output logic [15:0] inkr2,
    output logic [15:0] inkr3,
    output logic [15:0] inkr4,
    output logic [4:0]  border
);

    logic [COLOUR_W-1:0]  ink_q [INK_COUNT];
    logic [COLOUR_W-1:0]  ink_d [INK_COUNT];
    logic [COLOUR_W-1:0]  border_q;
    logic [COLOUR_W-1:0]  border_d;
    logic [INK_COUNT-1:0] plane [COLOUR_W];

    always_comb begin
        ink_d    = ink_q;
        border_d = border_q;
        if (wr_en) begin
            if (wr_border) begin
                border_d = wr_data;
            end else begin
                ink_d[wr_idx] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ink_q    <= '{default: '0};
            border_q <= '0;
        end else begin
            ink_q    <= ink_d;
            border_q <= border_d;
        end
    end

    // Transpose: plane b collects colour bit b of every ink.
    always_comb begin
        plane = '{default: '0};
        for (int unsigned n = 0; n < INK_COUNT; n++) begin
            for (int unsigned b = 0; b < COLOUR_W; b++) begin
                plane[b][n] = ink_q[n][b];
            end
        end
    end

    assign inkr0  = plane[0];
    assign inkr1  = plane[1];
    assign inkr2  = plane[2];
    assign inkr3  = plane[3];
    assign inkr4  = plane[4];
    assign border = border_q;

endmodule

// File: rtl/palette_control.sv
// Gate-array write decode: pen select, ink/border writes, ROM config, HSYNC-deferred
// mode changes and the interrupt-counter reset pulse.
module palette_control
    import palette_control_pkg::*;
(
    input  logic        CLK_n,
    input  logic        RESET,
    input  logic        WR_STB,
    input  logic [7:0]  D,
    input  logic        HSYNC,
    output logic [15:0] INKR0,
    output logic [15:0] INKR1,
    output logic [15:0] INKR2,
    output logic [15:0] INKR3,
    output logic [15:0] INKR4,
    output logic [4:0]  BORDER,
    output logic [4:0]  PEN,
    output logic [1:0]  MODE,
    output logic        MODE_IS_0,
    output logic        MODE_IS_2,
    output logic [1:0]  ROM_CFG,
    output logic        INT_RESET
);

    cmd_e             cmd;
    logic [PEN_W-1:0] pen_q, pen_d;
    mode_e            mode_q, mode_d;
    mode_e            mode_pend_q, mode_pend_d;
    logic [1:0]       rom_cfg_q, rom_cfg_d;
    logic             int_reset_q, int_reset_d;
    logic             hs_q, hs_d;
    logic             hs_rise;
    logic             ink_wr;
    logic             unused_d5;

    assign cmd       = cmd_e'(D[7:6]);
    assign hs_rise   = HSYNC & ~hs_q;
    assign unused_d5 = D[5];

    always_comb begin
        pen_d       = pen_q;
        mode_pend_d = mode_pend_q;
        rom_cfg_d   = rom_cfg_q;
        int_reset_d = 1'b0;
        ink_wr      = 1'b0;
        hs_d        = HSYNC;
        mode_d      = mode_q;
        if (WR_STB) begin
            case (cmd)
                CMD_PEN: pen_d = D[4:0];
                CMD_INK: ink_wr = 1'b1;
                CMD_CFG: begin
                    rom_cfg_d   = D[3:2];
                    mode_pend_d = mode_e'(D[1:0]);
                    int_reset_d = D[4];
                end
                default: ;
            endcase
        end
        // Using the next pending value lets a same-cycle CFG write win over the old one.
        if (hs_rise) begin
            mode_d = mode_pend_d;
        end
    end

    always_ff @(posedge CLK_n or posedge RESET) begin
        if (RESET) begin
            pen_q       <= '0;
            mode_q      <= MODE_0;
            mode_pend_q <= MODE_0;
            rom_cfg_q   <= '0;
            int_reset_q <= 1'b0;
            hs_q        <= 1'b0;
        end else begin
            pen_q       <= pen_d;
            mode_q      <= mode_d;
            mode_pend_q <= mode_pend_d;
            rom_cfg_q   <= rom_cfg_d;
            int_reset_q <= int_reset_d;
            hs_q        <= hs_d;
        end
    end

    ink_palette u_ink_palette (
        .clk       (CLK_n),
        .rst       (RESET),
        .wr_en     (ink_wr),
        .wr_border (pen_q[4]),
        .wr_idx    (pen_q[3:0]),
        .wr_data   (D[4:0]),
        .inkr0     (INKR0),
        .inkr1     (INKR1),
        .inkr2     (INKR2),
        .inkr3     (INKR3),
        .inkr4     (INKR4),
        .border    (BORDER)
    );

    assign PEN       = pen_q;
    assign MODE      = mode_q;
    assign MODE_IS_0 = (mode_q == MODE_0);
    assign MODE_IS_2 = (mode_q == MODE_2);
    assign ROM_CFG   = rom_cfg_q;
    assign INT_RESET = int_reset_q;

endmodule

// File: doc/palette_control.md
PALETTE_CONTROL -- requirements
Module: palette_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 CLK_n  in  1  block clock; all state SHALL update on its rising edge.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 WR_STB  in  1  one-cycle strobe; an already-decoded CPU write to the gate array is valid this cycle.
REQ-005 D  in  8  CPU write data; sampled only when WR_STB=1.
REQ-006 HSYNC  in  1  horizontal sync from the CRTC.
REQ-007 INKR0..INKR4  out  16 each  palette bit-planes; INKRb[n] = colour bit b of ink n, driving the ColourMuxBit instances.
REQ-008 BORDER  out  5  border colour.
REQ-009 PEN  out  5  currently selected pen.
REQ-010 MODE  out  2  active screen mode.
REQ-011 MODE_IS_0, MODE_IS_2  out  1 each  decoded from MODE.
REQ-012 ROM_CFG  out  2  ROM disable bits: [1] upper, [0] lower.
REQ-013 INT_RESET  out  1  one-cycle pulse that clears the interrupt counter.

Function
REQ-014 WR_STB=1 with D[7:6]=00 (PEN) SHALL load PEN<=D[4:0]; PEN[4]=1 selects the border and PEN[3:0] is then don't-care.
REQ-015 WR_STB=1 with D[7:6]=01 (INK) SHALL write D[4:0] into BORDER if PEN[4]=1, else into ink PEN[3:0].
REQ-016 The PEN value used by an INK write SHALL be the registered PEN from before that cycle.
REQ-017 An INK write SHALL be visible on INKR0..4 or BORDER in the cycle after the strobe (1-cycle latency).
REQ-018 WR_STB=1 with D[7:6]=10 (CFG) SHALL load ROM_CFG<=D[3:2] with 1-cycle latency.
REQ-019 A CFG write SHALL load mode_pend<=D[1:0] and SHALL leave MODE unchanged.
REQ-020 A CFG write with D[4]=1 SHALL pulse INT_RESET high for exactly the following cycle.
REQ-021 WR_STB=1 with D[7:6]=11 SHALL be ignored; no state changes.
REQ-022 HSYNC SHALL be registered into hs_q; the HSYNC rise SHALL be detected as HSYNC=1 & hs_q=0.
REQ-023 On a detected HSYNC rise, MODE SHALL take mode_pend in the next cycle; MODE SHALL not change at any other time.
REQ-024 If a CFG write and an HSYNC rise occur in the same cycle, MODE SHALL take the newly written D[1:0].
REQ-025 Several CFG writes between HSYNC rises SHALL leave MODE at the last written value.
REQ-026 HSYNC held high SHALL cause only one MODE update per rising edge.
REQ-027 MODE_IS_0=(MODE==0) and MODE_IS_2=(MODE==2) SHALL be combinational from MODE; MODE=3 SHALL assert neither.
REQ-028 WR_STB=0 SHALL leave all palette, pen and config state unchanged.

Reset
REQ-029 While RESET=1, the block SHALL hold PEN=0, all 16 inks=0, BORDER=0, MODE=0, mode_pend=0, ROM_CFG=00, INT_RESET=0 and hs_q=0.
REQ-030 Reset values imply MODE_IS_0=1 and MODE_IS_2=0.
REQ-031 A reset asserted mid-operation SHALL discard a pending mode and cancel an in-flight INT_RESET pulse.
REQ-032 No write SHALL take effect in the cycle RESET deasserts.
REQ-033 After RESET deasserts, an HSYNC already high SHALL count as a rising edge.

Structure
REQ-034 A shared package SHALL hold the command codes CMD_PEN=00, CMD_INK=01, CMD_CFG=10, CMD_RAM=11, plus colour width 5, ink count 16 and the mode encodings.
REQ-035 A sub-module ink_palette SHALL hold the 16x5 ink storage plus BORDER and transpose it into the INKR0..4 bit-planes.
REQ-036 The decode, mode-deferral and pulse logic SHALL remain in palette_control.

Verification
REQ-037 After reset, write 0x03 then 0x54 -> next cycle INKR4..0 bit 3 = 1,0,1,0,0 and all other inks stay 0.
REQ-038 Write 0x10 then 0x4B -> BORDER=0x0B and INKR0..4 unchanged.
REQ-039 Write 0x8E with HSYNC low -> ROM_CFG=11 and MODE stays 0; then HSYNC rise -> MODE=2, MODE_IS_2=1 one cycle after the edge.
REQ-040 Write 0x81 in the same cycle as an HSYNC rise -> MODE=1 the next cycle; write 0x82 then 0x83 before the next rise -> MODE=3 and both MODE_IS flags 0.
REQ-041 Write 0x90 -> INT_RESET high for exactly one cycle; 0xC7 -> no output changes.
REQ-042 Write 0x82, then assert RESET before HSYNC rises -> MODE stays 0 after the rise and all outputs return to reset values.
